// File: rtl/switch_input_ctrl.sv
// switch_input_ctrl
//   Conditions the board's raw switch/button pins before the CPU reads them.
//   Each bit goes through a 2-flop synchronizer and a counter debouncer. The
//   block then produces one-cycle rise/fall pulses and a sticky event flag,
//   which the CPU acknowledges with a per-bit clear strobe.
//
// Parameters
//   N_SW    number of input bits
//   DB_CNT  consecutive cycles s2 must differ from the stable level before the
//           new level is accepted (>= 1)
//
// Ports
//   clk          system clock (rising edge)
//   rst          asynchronous active-high reset
//   sw_raw       raw asynchronous pin levels
//   evt_clr      per-bit clear strobe for evt_pending
//   sw_stable    debounced level
//   sw_rise      one-cycle pulse on sw_stable 0->1
//   sw_fall      one-cycle pulse on sw_stable 1->0
//   evt_pending  sticky per-bit event flag
//   evt_any      OR of evt_pending
module switch_input_ctrl #(
  parameter int N_SW   = 12,
  parameter int DB_CNT = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  input  logic [N_SW-1:0] evt_clr,
  output logic [N_SW-1:0] sw_stable,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] evt_pending,
  output logic            evt_any
);

  localparam int              CNT_W   = $clog2(DB_CNT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

  logic [N_SW-1:0]  sync1_q, sync2_q;
  logic [N_SW-1:0]  stable_q, stable_d;
  logic [N_SW-1:0]  rise_q, rise_d;
  logic [N_SW-1:0]  fall_q, fall_d;
  logic [N_SW-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q [N_SW];
  logic [CNT_W-1:0] cnt_d [N_SW];

  // Debounce and event next-state
  always_comb begin
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        // Any sample matching the stable level discards accumulated credit.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
        rise_d[i]   = sync2_q[i];
        fall_d[i]   = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    // A newly accepted edge overrides a clear arriving in the same cycle.
    pend_d = rise_d | fall_d | (pend_q & ~evt_clr);
  end

  // Register stage: synchronizer, counters, outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      pend_q   <= '0;
      for (int i = 0; i < N_SW; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q  <= sw_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
      for (int i = 0; i < N_SW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sw_stable   = stable_q;
  assign sw_rise     = rise_q;
  assign sw_fall     = fall_q;
  assign evt_pending = pend_q;
  assign evt_any     = |pend_q;

endmodule

// File: doc/switch_input_ctrl.md
Name: switch_input_ctrl

Overview:
- Input-side counterpart of the 7-segment/LED display path: conditions the board's raw switch and button inputs before the CPU reads them.
- Per input bit: 2-flop synchronizer, then a counter-based debouncer, then one-cycle rise/fall pulses and sticky event flags. The CPU acknowledges each event with a clear mask.
- Sits between the board pins and CPU_MOD's switch input. It is clocked by the same clock as the consumer, normally clk_cpu.

Parameters:
- N_SW, 12, number of input bits (10 switches + stop + Debug_DM).
- DB_CNT, 1000000, consecutive cycles a synchronized input must differ from the stable value before it is accepted. Must be ≥ 1.
- CNT_W, $clog2(DB_CNT)+1, counter width. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- sw_raw  input  N_SW  raw, asynchronous, bouncing pin levels.
- evt_clr  input  N_SW  per-bit clear strobe for evt_pending. Sampled each cycle.
- sw_stable  output  N_SW  debounced level.
- sw_rise  output  N_SW  one-cycle pulse when sw_stable goes 0->1.
- sw_fall  output  N_SW  one-cycle pulse when sw_stable goes 1->0.
- evt_pending  output  N_SW  sticky flag: set on any accepted edge, cleared via evt_clr.
- evt_any  output  1  OR-reduction of evt_pending (combinational from the registers).

Behaviour:
- Reset, asynchronous, while rst=1: sync stage 1 and stage 2, all counters, sw_stable, sw_rise, sw_fall and evt_pending are 0. evt_any is therefore 0.
- Synchronizer per bit: s1<=sw_raw, s2<=s1. There is no logic between s1 and s2.
- Debounce per bit, each edge:
  - s2==sw_stable: cnt<=0.
  - s2!=sw_stable and cnt<DB_CNT-1: cnt<=cnt+1.
  - s2!=sw_stable and cnt==DB_CNT-1: sw_stable<=s2, cnt<=0, and a pulse is registered.
- Any glitch shorter than DB_CNT cycles at s2 returns cnt to 0 and leaves sw_stable unchanged. There is no partial credit across glitches.
- Latency: a raw step first sampled at edge k appears on sw_stable at edge k+1+DB_CNT. Two synchronizer edges, with the first counted at k, then DB_CNT compare edges.
- Pulses: sw_rise/sw_fall are registered on the same edge as the sw_stable update. Each is high for exactly one cycle, then returns to 0. Rise and fall are never high together on one bit.
- Event flags per bit, each edge:
  - Accepted edge (rise or fall) this cycle: evt_pending<=1, even if evt_clr is also 1 that cycle. The new event wins.
  - Otherwise, evt_clr=1: evt_pending<=0.
  - Otherwise: hold.
  - evt_clr on a bit that is already 0 has no effect.
- Bits are fully independent. Simultaneous edges on multiple bits each produce their own pulse and flag in the same cycle.
- DB_CNT=1: sw_stable follows s2 with one cycle of delay. Every s2 change produces a pulse.
- Power-up with an input held at 1: after reset release, that bit produces one sw_rise and sets evt_pending after 2+DB_CNT edges. This is intended; the CPU sees the initial switch state as an event.
- rst asserted mid-count: all state clears immediately. After release, counting restarts from 0.
- Counter never exceeds DB_CNT-1. No wrap-around is possible.

Test Plan:
All scenarios use DB_CNT=4, N_SW=12.
1. Reset, sw_raw=0 -> all outputs 0. Raise sw_raw[0] before edge 1 -> sw_stable[0]=1 and sw_rise[0]=1 after edge 6. sw_rise[0]=0 after edge 7. evt_pending[0]=1, evt_any=1.
2. Bounce: sw_stable[3]=0. sw_raw[3] pattern 1,1,1,0,1,1,1,1 (one value per cycle) -> no change during the first 3-cycle burst. sw_stable[3] rises only after 4 consecutive 1s at s2. Exactly one sw_rise[3] pulse.
3. Fall: sw_stable[5]=1, drop sw_raw[5] -> sw_fall[5] one-cycle pulse 6 edges later. sw_rise[5] stays 0. evt_pending[5] set.
4. Clear handshake: evt_pending=12'h001, evt_clr=12'h001 for one cycle -> evt_pending=0, evt_any=0. Repeat with an accepted edge on bit 0 in the same cycle as evt_clr -> evt_pending[0] stays 1.
5. Multi-bit: sw_raw 12'h000->12'hFFF in one step -> all 12 sw_rise bits pulse on the same edge. evt_pending=12'hFFF.
6. Reset mid-count: sw_raw[2]=1, assert rst 3 cycles after the change -> all outputs 0 immediately. After release with sw_raw[2] still 1 -> sw_stable[2]=1 exactly 6 edges later.
